// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults and types for the register-file writeback
//                unit. DEF_ADDRESS_WIDTH / DEF_DATA_WIDTH are the default
//                register index and data widths; wb_entry_t is one pending
//                register write {rd, data}.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_FIFO_DEPTH    = 4;

    typedef struct packed {
        logic [DEF_ADDRESS_WIDTH-1:0] rd;
        logic [DEF_DATA_WIDTH-1:0]    data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Circular writeback queue with two push ports and one pop.
//                Push 0 is written before push 1 in the same cycle, so push 0
//                is the older entry. The head is popped on every cycle the
//                queue is non-empty. With REGFILE_WB_BYPASS_EN defined the
//                storage, read pointer and count are exported for forwarding.
//  Ports       : clk, rst_n          clock, async active-low reset
//                i_push0_*           first (older) push: valid/rd/data
//                i_push1_*           second (younger) push: valid/rd/data
//                o_count             occupancy at cycle start
//                o_head_valid/rd/data  entry popped this cycle
//                o_rd_ptr, o_entry_rd, o_entry_data  (bypass build only)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int PW            = $clog2(FIFO_DEPTH),
    parameter int CW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push0_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_push0_rd,
    input  logic [DATA_WIDTH-1:0]    i_push0_data,
    input  logic                     i_push1_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_push1_rd,
    input  logic [DATA_WIDTH-1:0]    i_push1_data,
    output logic [CW-1:0]            o_count,
    output logic                     o_head_valid,
    output logic [ADDRESS_WIDTH-1:0] o_head_rd,
    output logic [DATA_WIDTH-1:0]    o_head_data
`ifdef REGFILE_WB_BYPASS_EN
   ,output logic [PW-1:0]            o_rd_ptr,
    output logic [ADDRESS_WIDTH-1:0] o_entry_rd   [FIFO_DEPTH],
    output logic [DATA_WIDTH-1:0]    o_entry_data [FIFO_DEPTH]
`endif
);

    logic [ADDRESS_WIDTH-1:0] r_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    r_data [FIFO_DEPTH];
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;

    logic                     w_pop;
    logic [PW-1:0]            w_wr_ptr1;
    logic [CW:0]              w_count_ext;

    assign w_pop = (r_count != '0);

    // The younger push lands one slot after the older one when both fire.
    assign w_wr_ptr1 = r_wr_ptr + {{(PW-1){1'b0}}, i_push0_valid};

    // One extra bit so an overflow is visible rather than wrapping.
    assign w_count_ext = {1'b0, r_count}
                       + {{CW{1'b0}}, i_push0_valid}
                       + {{CW{1'b0}}, i_push1_valid}
                       - {{CW{1'b0}}, w_pop};

    // Storage needs no reset: only slots covered by r_count are ever read.
    always_ff @(posedge clk) begin
        if (i_push0_valid) begin
            r_rd[r_wr_ptr]   <= i_push0_rd;
            r_data[r_wr_ptr] <= i_push0_data;
        end
        if (i_push1_valid) begin
            r_rd[w_wr_ptr1]   <= i_push1_rd;
            r_data[w_wr_ptr1] <= i_push1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr1 + {{(PW-1){1'b0}}, i_push1_valid};
            r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, w_pop};
            r_count  <= w_count_ext[CW-1:0];
        end
    end

`ifndef SYNTHESIS
    // A load may only arrive on a full queue when the head is leaving.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (int'(w_count_ext) <= FIFO_DEPTH)
                else $error("wb_fifo: push on full queue without pop");
        end
    end
`endif

    assign o_count      = r_count;
    assign o_head_valid = w_pop;
    assign o_head_rd    = r_rd[r_rd_ptr];
    assign o_head_data  = r_data[r_rd_ptr];

`ifdef REGFILE_WB_BYPASS_EN
    assign o_rd_ptr     = r_rd_ptr;
    assign o_entry_rd   = r_rd;
    assign o_entry_data = r_data;
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback
//  Description : Writeback unit driving the register file write port.
//                Load returns (never back-pressured) and ALU results
//                (valid/ready) are merged into an in-order queue; one write
//                per cycle is issued on WE3/AD3/WD3. A per-register busy
//                scoreboard tracks loads in flight so decode can stall.
//                Optional macro REGFILE_WB_BYPASS_EN adds two forwarding
//                read ports (fwd1/fwd2) over the queue and output register.
//  Ports       : clk, rst_n                      clock, async active-low reset
//                alu_valid/ready/rd/data         ALU result handshake
//                ld_valid/rd/data                load data return
//                issue_valid/rd                  load issued to memory
//                WE3/AD3/WD3                     registered RF write port
//                busy                            registered load scoreboard
//                fwd*_rd/hit/data                bypass ports (macro only)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDRESS_WIDTH-1:0]      alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          ld_valid,
    input  logic [ADDRESS_WIDTH-1:0]      ld_rd,
    input  logic [DATA_WIDTH-1:0]         ld_data,
    input  logic                          issue_valid,
    input  logic [ADDRESS_WIDTH-1:0]      issue_rd,
    output logic                          WE3,
    output logic [ADDRESS_WIDTH-1:0]      AD3,
    output logic [DATA_WIDTH-1:0]         WD3,
    output logic [(2**ADDRESS_WIDTH)-1:0] busy
`ifdef REGFILE_WB_BYPASS_EN
   ,input  logic [ADDRESS_WIDTH-1:0]      fwd1_rd,
    output logic                          fwd1_hit,
    output logic [DATA_WIDTH-1:0]         fwd1_data,
    input  logic [ADDRESS_WIDTH-1:0]      fwd2_rd,
    output logic                          fwd2_hit,
    output logic [DATA_WIDTH-1:0]         fwd2_data
`endif
);

    localparam int NREG = 2 ** ADDRESS_WIDTH;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] C_READY_MAX = CW'(FIFO_DEPTH - 2);

    logic                     w_ld_push;
    logic                     w_alu_push;
    logic [CW-1:0]            w_count;
    logic                     w_head_valid;
    logic [ADDRESS_WIDTH-1:0] w_head_rd;
    logic [DATA_WIDTH-1:0]    w_head_data;
    logic [NREG-1:0]          w_busy_next;

    logic                     r_we3;
    logic [ADDRESS_WIDTH-1:0] r_ad3;
    logic [DATA_WIDTH-1:0]    r_wd3;
    logic [NREG-1:0]          r_busy;

    // Room for one ALU entry plus a possible same-cycle load.
    assign alu_ready  = (w_count <= C_READY_MAX);

    // Writes to x0 are dropped here so they never occupy a slot.
    assign w_ld_push  = ld_valid && (ld_rd != '0);
    assign w_alu_push = alu_valid && alu_ready && (alu_rd != '0);

`ifdef REGFILE_WB_BYPASS_EN
    logic [PW-1:0]            w_rd_ptr;
    logic [ADDRESS_WIDTH-1:0] w_entry_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    w_entry_data [FIFO_DEPTH];
`endif

    wb_fifo #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .PW            (PW),
        .CW            (CW)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push0_valid (w_ld_push),
        .i_push0_rd    (ld_rd),
        .i_push0_data  (ld_data),
        .i_push1_valid (w_alu_push),
        .i_push1_rd    (alu_rd),
        .i_push1_data  (alu_data),
        .o_count       (w_count),
        .o_head_valid  (w_head_valid),
        .o_head_rd     (w_head_rd),
        .o_head_data   (w_head_data)
`ifdef REGFILE_WB_BYPASS_EN
       ,.o_rd_ptr      (w_rd_ptr),
        .o_entry_rd    (w_entry_rd),
        .o_entry_data  (w_entry_data)
`endif
    );

    // Clear first, then set, so an issue and a return for the same register
    // in one cycle leave it busy (the new load is still outstanding).
    always_comb begin
        w_busy_next = r_busy;
        if (ld_valid) begin
            w_busy_next[ld_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            w_busy_next[issue_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we3  <= 1'b0;
            r_ad3  <= '0;
            r_wd3  <= '0;
            r_busy <= '0;
        end else begin
            r_we3  <= w_head_valid;
            if (w_head_valid) begin
                r_ad3 <= w_head_rd;
                r_wd3 <= w_head_data;
            end
            r_busy <= w_busy_next;
        end
    end

    assign WE3  = r_we3;
    assign AD3  = r_ad3;
    assign WD3  = r_wd3;
    assign busy = r_busy;

`ifdef REGFILE_WB_BYPASS_EN
    logic [ADDRESS_WIDTH-1:0] w_fwd_rd   [2];
    logic                     w_fwd_hit  [2];
    logic [DATA_WIDTH-1:0]    w_fwd_data [2];

    assign w_fwd_rd[0] = fwd1_rd;
    assign w_fwd_rd[1] = fwd2_rd;

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        // Scan oldest to youngest (output register, then head..tail) so the
        // last match, the youngest, supplies the data.
        always_comb begin
            w_fwd_hit[p]  = 1'b0;
            w_fwd_data[p] = '0;
            if (w_fwd_rd[p] != '0) begin
                if (r_we3 && (r_ad3 == w_fwd_rd[p])) begin
                    w_fwd_hit[p]  = 1'b1;
                    w_fwd_data[p] = r_wd3;
                end
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if ((i < int'(w_count)) &&
                        (w_entry_rd[w_rd_ptr + PW'(i)] == w_fwd_rd[p])) begin
                        w_fwd_hit[p]  = 1'b1;
                        w_fwd_data[p] = w_entry_data[w_rd_ptr + PW'(i)];
                    end
                end
            end
        end
    end

    assign fwd1_hit  = w_fwd_hit[0];
    assign fwd1_data = w_fwd_data[0];
    assign fwd2_hit  = w_fwd_hit[1];
    assign fwd2_data = w_fwd_data[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_writeback
//  Description : Directed self-checking bench for regfile_writeback. A queue
//                of expected writes is filled as stimulus is applied and
//                drained against WE3/AD3/WD3 each cycle; alu_ready and busy
//                are tracked by a small reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;
    import regfile_pkg::*;

    localparam int AW    = DEF_ADDRESS_WIDTH;
    localparam int DW    = DEF_DATA_WIDTH;
    localparam int DEPTH = DEF_FIFO_DEPTH;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid, alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [DW-1:0]   alu_data;
    logic            ld_valid;
    logic [AW-1:0]   ld_rd;
    logic [DW-1:0]   ld_data;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            WE3;
    logic [AW-1:0]   AD3;
    logic [DW-1:0]   WD3;
    logic [(2**AW)-1:0] busy;
`ifdef REGFILE_WB_BYPASS_EN
    logic [AW-1:0]   fwd1_rd, fwd2_rd;
    logic            fwd1_hit, fwd2_hit;
    logic [DW-1:0]   fwd1_data, fwd2_data;
`endif

    regfile_writeback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .WE3         (WE3),
        .AD3         (AD3),
        .WD3         (WD3),
        .busy        (busy)
`ifdef REGFILE_WB_BYPASS_EN
       ,.fwd1_rd     (fwd1_rd),
        .fwd1_hit    (fwd1_hit),
        .fwd1_data   (fwd1_data),
        .fwd2_rd     (fwd2_rd),
        .fwd2_hit    (fwd2_hit),
        .fwd2_data   (fwd2_data)
`endif
    );

    always #5 clk = ~clk;

    int              n_tests = 0;
    int              n_fail  = 0;
    int              saw_low = 0;
    wb_entry_t       q[$];
    logic            exp_we  = 1'b0;
    logic [AW-1:0]   exp_ad  = '0;
    logic [DW-1:0]   exp_wd  = '0;
    logic [(2**AW)-1:0] exp_busy = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        ld_valid    = 1'b0;
        ld_rd       = '0;
        ld_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    // Advance one clock with the currently driven inputs and check outputs.
    task automatic step(output bit acc);
        bit        exp_ready;
        wb_entry_t e;
        exp_ready = (q.size() <= DEPTH - 2);
        check("alu_ready", {63'd0, alu_ready}, {63'd0, exp_ready});
        if (alu_ready === 1'b0) saw_low++;
        acc = alu_valid && exp_ready;
        if (q.size() > 0) begin
            e      = q.pop_front();
            exp_we = 1'b1;
            exp_ad = e.rd;
            exp_wd = e.data;
        end else begin
            exp_we = 1'b0;
        end
        if (ld_valid && ld_rd != '0) begin
            e.rd = ld_rd; e.data = ld_data; q.push_back(e);
        end
        if (acc && alu_rd != '0) begin
            e.rd = alu_rd; e.data = alu_data; q.push_back(e);
        end
        if (ld_valid) exp_busy[ld_rd] = 1'b0;
        if (issue_valid && issue_rd != '0) exp_busy[issue_rd] = 1'b1;
        @(posedge clk);
        #1;
        check("WE3",  {63'd0, WE3}, {63'd0, exp_we});
        check("AD3",  {59'd0, AD3}, {59'd0, exp_ad});
        check("WD3",  {32'd0, WD3}, {32'd0, exp_wd});
        check("busy", {32'd0, busy}, {32'd0, exp_busy});
    endtask

    task automatic idle(input int n);
        bit acc;
        clear_inputs();
        for (int i = 0; i < n; i++) step(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int k;
        int guard;

        // Reset held with an ALU offer: nothing may be enqueued.
        clear_inputs();
`ifdef REGFILE_WB_BYPASS_EN
        fwd1_rd = '0;
        fwd2_rd = '0;
`endif
        rst_n     = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd4;
        alu_data  = 32'h1234;
        #1;
        check("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_WE3",  {63'd0, WE3}, 64'd0);
            check("rst_busy", {32'd0, busy}, 64'd0);
            check("rst_AD3",  {59'd0, AD3}, 64'd0);
            check("rst_WD3",  {32'd0, WD3}, 64'd0);
        end
        clear_inputs();
        rst_n = 1'b1;
        idle(2);

        // Single ALU write, rd=5.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step(acc);
        idle(3);

        // Load and ALU to the same register in one cycle: load first.
        ld_valid  = 1'b1; ld_rd  = 5'd3; ld_data  = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
        step(acc);
        idle(3);

        // Writes to x0 are dropped.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        step(acc);
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h66;
        step(acc);
        idle(2);

        // Back-pressure: six ALU results with competing loads.
        k = 0;
        guard = 0;
        saw_low = 0;
        while (k < 6 && guard < 50) begin
            clear_inputs();
            alu_valid = 1'b1;
            alu_rd    = AW'(10 + k);
            alu_data  = 32'h100 + 32'(k);
            ld_valid  = (guard < 4);
            ld_rd     = AW'(20 + (guard % 8));
            ld_data   = 32'h200 + 32'(guard);
            step(acc);
            if (acc) k++;
            guard++;
        end
        check("bp_ready_dropped", {63'd0, (saw_low != 0)}, 64'd1);
        idle(8);

        // Scoreboard set / same-cycle set-and-clear / clear.
        issue_valid = 1'b1; issue_rd = 5'd7;
        step(acc);
        clear_inputs();
        issue_valid = 1'b1; issue_rd = 5'd7;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        step(acc);
        idle(2);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h78;
        step(acc);
        clear_inputs();
        issue_valid = 1'b1; issue_rd = 5'd0;
        step(acc);
        idle(3);

`ifdef REGFILE_WB_BYPASS_EN
        // Two queued writes to x9: the younger (ALU) value must forward.
        ld_valid  = 1'b1; ld_rd  = 5'd9; ld_data  = 32'hA;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hB;
        step(acc);
        clear_inputs();
        fwd1_rd = 5'd9;
        fwd2_rd = 5'd0;
        #1;
        check("fwd1_hit",  {63'd0, fwd1_hit}, 64'd1);
        check("fwd1_data", {32'd0, fwd1_data}, 64'hB);
        check("fwd2_hit0", {63'd0, fwd2_hit}, 64'd0);
        fwd1_rd = 5'd0;
        #1;
        check("fwd1_hit0", {63'd0, fwd1_hit}, 64'd0);
        idle(4);
`endif

        // Reset mid-operation flushes the queue and the scoreboard.
        issue_valid = 1'b1; issue_rd = 5'd12;
        ld_valid  = 1'b1; ld_rd  = 5'd13; ld_data  = 32'h301;
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h302;
        step(acc);
        step(acc);
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_WE3",   {63'd0, WE3}, 64'd0);
        check("mid_rst_busy",  {32'd0, busy}, 64'd0);
        check("mid_rst_ready", {63'd0, alu_ready}, 64'd1);
        q.delete();
        exp_we = 1'b0; exp_ad = '0; exp_wd = '0; exp_busy = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
